vec_mem_sequencer: RTL
======================

# vec_mem_sequencer

Sequences data-memory accesses from the core onto a single-port, 32-bit-wide data RAM. A 192-bit vector access (`VecOp=1`) becomes six consecutive word beats; a scalar access becomes one beat. The block assembles read lanes into `rd` and holds the requester with `busy` until `ack`. It sits between the execute/memory stage and the data RAM, alongside instruction fetch, which it does not touch.

## Interface
- `DATA_W`, default 32: RAM word width; one vector lane.
- `LANES`, default 6: beats per vector access; `LANES*DATA_W = 192`.
- `RAM_BASE`, default 31000: word address that maps to RAM word 0.
- `RAM_DEPTH`, default 4096: RAM words; `ram_addr` width is `AW = $clog2(RAM_DEPTH)`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req` in 1: core access request; held high until `ack`.
- `we` in 1: 1 = write, 0 = read; sampled with `req`.
- `VecOp` in 1: 1 = 6-beat vector access, 0 = scalar; sampled with `req`.
- `address` in 32: word address of lane 0.
- `wd` in 192: write data; lane i = `wd[32i+31:32i]`.
- `rd` out 192: read result; holds its value until the next read completes.
- `busy` out 1: high in every state except IDLE.
- `ack` out 1: one-cycle completion pulse.
- `err` out 1: high with `ack` when the access is out of range.
- `ram_en` out 1: RAM access strobe.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out AW: RAM word index.
- `ram_wd` out 32: RAM write data.
- `ram_rd` in 32: RAM read data; valid the cycle after `ram_en` with `!ram_we`.

## Operation
- **States:** IDLE, ACCESS, DRAIN, DONE.
- **IDLE:**
  - On `req=1`, capture `address`, `we`, `VecOp`, `wd`.
  - Set beat count N = `VecOp` ? 6 : 1 and beat index i = 0.
  - Range check: `address < RAM_BASE` or `address + N > RAM_BASE + RAM_DEPTH` goes to DONE with `err` set and no RAM access. Otherwise go to ACCESS.
- **ACCESS:**
  - Each cycle drives `ram_en=1`, `ram_we=we`, `ram_addr = address - RAM_BASE + i`, `ram_wd = lane i`, then increments i.
  - After beat N-1, a write goes to DONE and a read goes to DRAIN.
- **Read capture:** `ram_rd` from beat i-1 is written into `rd` lane i-1 on every ACCESS and DRAIN cycle with i > 0.
- **Scalar read:** zeroes `rd` lanes 1..5.
- **DRAIN:** captures the last lane, then goes to DONE.
- **DONE:** asserts `ack` (and `err` if flagged) for one cycle, then returns to IDLE.
- **Writes** never modify `rd`.
- **Requester rule:** `req` must be low in the cycle after `ack`. A `req` seen high in IDLE is always a new request.
- **Outputs outside ACCESS:** `ram_en=0` and `ram_we=0`.
- **Address arithmetic:** the range check uses 33-bit unsigned arithmetic, so `address + N` cannot wrap.

## Timing
- Cycle 0 is the IDLE cycle in which `req` is sampled.
- `ack` latency from cycle 0:
  - scalar write: 2
  - scalar read: 3
  - vector write: 7
  - vector read: 8
  - range error: 1
- `rd` is fully updated in the same cycle `ack` is high.
- **Reset value of every output:** `rd=0`, `busy=0`, `ack=0`, `err=0`, `ram_en=0`, `ram_we=0`, `ram_addr=0`, `ram_wd=0`.
- **Reset mid-operation:** returns immediately to IDLE with no `ack`. RAM words already written stay written. `rd` is cleared.

## Configuration
- **`LOADER_PORT_EN` defined:** adds a second requester for memory initialisation.
  - Added ports: `ld_req` in 1, `ld_addr` in 32, `ld_wd` in 32, `ld_ack` out 1.
  - Loader accesses are scalar writes only, using the same range check. An out-of-range loader access returns `ld_ack` with `err`.
  - In IDLE, `ld_req` wins over `req` when both are high. The core request waits, with `busy` high for the loader transaction.
  - `ld_ack` pulses in DONE for loader transactions; `ack` stays low for them.
- **`LOADER_PORT_EN` not defined:** the loader ports do not exist and the core is the sole requester.

## Test plan
- **Scalar write then read.** Write `address=31000`, `wd=3`, then read it back. Required: `ram_addr=0`; `ack` at cycles 2 and 3 respectively; then `rd=192'd3`.
- **Vector write then read.** Write `address=31005`, `VecOp=1`, `wd=64'd1234567891123`, then read it back. Required: `ram_addr` 5..10 on six consecutive cycles; `ack` at cycle 8 of the read; `rd` equals `wd`; lanes 2..5 are 0.
- **Out-of-range accesses.**
  - `address=1000` gives `ack`+`err` at cycle 1 and `ram_en` never asserts.
  - `address=35094` with `VecOp=1` (last beat exceeds 35095) gives `err`.
  - `address=35095`, scalar, succeeds.
- **Reset mid-operation.** Assert `rst` during beat 3 of a vector write. Required: all outputs at reset values, no `ack`; a following scalar read of beat 0 returns the new data.
- **Back-to-back requests.** `req` low for one cycle after `ack`, then a new request. Required: accepted, with no lost or duplicated `ack`; `busy` low exactly in the IDLE cycles.
- **Loader priority (`LOADER_PORT_EN` only).** `ld_req` and `req` both rise in the same IDLE cycle. Required: `ld_ack` at cycle 2, then the core `ack` follows its own latency counted from the loader transaction's return to IDLE.

Source files
------------

// File: rtl/vec_mem_sequencer_if.sv
// Core-side request/response bundle for vec_mem_sequencer.
// The core is the master; the sequencer is the slave.
interface vec_mem_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 6
);
  logic                      req;
  logic                      we;
  logic                      VecOp;
  logic [31:0]               address;
  logic [LANES*DATA_W-1:0]   wd;
  logic [LANES*DATA_W-1:0]   rd;
  logic                      busy;
  logic                      ack;
  logic                      err;

  modport master (output req, we, VecOp, address, wd,
                  input  rd, busy, ack, err);
  modport slave  (input  req, we, VecOp, address, wd,
                  output rd, busy, ack, err);
endinterface

// File: rtl/vec_mem_sequencer.sv
// Sequences scalar/vector core accesses into 32-bit beats on a single-port data RAM.
// Optional memory-init loader requester is enabled by defining LOADER_PORT_EN.
module vec_mem_sequencer #(
  parameter int DATA_W    = 32,
  parameter int LANES     = 6,
  parameter int RAM_BASE  = 31000,
  parameter int RAM_DEPTH = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  vec_mem_sequencer_if.slave           core,
  output logic                         o_ram_en,
  output logic                         o_ram_we,
  output logic [$clog2(RAM_DEPTH)-1:0] o_ram_addr,
  output logic [DATA_W-1:0]            o_ram_wd,
  input  logic [DATA_W-1:0]            i_ram_rd
`ifdef LOADER_PORT_EN
  ,
  input  logic                         i_ld_req,
  input  logic [31:0]                  i_ld_addr,
  input  logic [DATA_W-1:0]            i_ld_wd,
  output logic                         o_ld_ack
`endif
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam int BW = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                        r_state;
  logic [BW-1:0]                 r_beat;
  logic                          r_we;
  logic                          r_vec;
  logic                          r_ld;
  logic [LANES-1:0][DATA_W-1:0]  r_wd;
  logic [LANES-1:0][DATA_W-1:0]  r_rd;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_err;
  logic                          r_ram_en;
  logic                          r_ram_we;
  logic [AW-1:0]                 r_ram_addr;
  logic [DATA_W-1:0]             r_ram_wd;

  logic                          w_req;
  logic                          w_req_ld;
  logic                          w_req_we;
  logic                          w_req_vec;
  logic [31:0]                   w_req_addr;
  logic [LANES-1:0][DATA_W-1:0]  w_req_wd;
  logic [32:0]                   w_req_end;
  logic                          w_oor;
  logic [BW-1:0]                 w_last_beat;
  logic [BW-1:0]                 w_next_beat;
  logic [BW-1:0]                 w_prev_beat;

`ifdef LOADER_PORT_EN
  // Loader has priority; its accesses are always scalar writes.
  assign w_req_ld   = i_ld_req;
  assign w_req      = i_ld_req | core.req;
  assign w_req_we   = i_ld_req ? 1'b1 : core.we;
  assign w_req_vec  = i_ld_req ? 1'b0 : core.VecOp;
  assign w_req_addr = i_ld_req ? i_ld_addr : core.address;
  assign w_req_wd   = i_ld_req ? {{((LANES-1)*DATA_W){1'b0}}, i_ld_wd} : core.wd;
  assign o_ld_ack   = r_done & r_ld;
`else
  assign w_req_ld   = 1'b0;
  assign w_req      = core.req;
  assign w_req_we   = core.we;
  assign w_req_vec  = core.VecOp;
  assign w_req_addr = core.address;
  assign w_req_wd   = core.wd;
`endif

  // 33-bit end address so a request near 2^32 cannot wrap past the check.
  assign w_req_end   = {1'b0, w_req_addr} + (w_req_vec ? 33'(LANES) : 33'd1);
  assign w_oor       = (w_req_addr < 32'(RAM_BASE)) ||
                       (w_req_end > 33'(RAM_BASE + RAM_DEPTH));
  assign w_last_beat = r_vec ? BW'(LANES - 1) : '0;
  assign w_next_beat = r_beat + BW'(1);
  assign w_prev_beat = r_beat - BW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_beat     <= '0;
      r_we       <= 1'b0;
      r_vec      <= 1'b0;
      r_ld       <= 1'b0;
      r_wd       <= '0;
      r_rd       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_wd   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_busy <= 1'b1;
            r_we   <= w_req_we;
            r_vec  <= w_req_vec;
            r_ld   <= w_req_ld;
            r_wd   <= w_req_wd;
            r_beat <= '0;
            if (w_oor) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state    <= S_ACCESS;
              r_ram_en   <= 1'b1;
              r_ram_we   <= w_req_we;
              r_ram_addr <= AW'(w_req_addr - 32'(RAM_BASE));
              r_ram_wd   <= w_req_wd[0];
            end
          end
        end
        S_ACCESS: begin
          // RAM returns the previous beat's word this cycle.
          if (r_beat != '0 && !r_we)
            r_rd[w_prev_beat] <= i_ram_rd;
          r_beat <= w_next_beat;
          if (r_beat == w_last_beat) begin
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            if (r_we) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_ram_addr <= r_ram_addr + AW'(1);
            r_ram_wd   <= r_wd[w_next_beat];
          end
        end
        S_DRAIN: begin
          if (r_vec) begin
            r_rd[w_prev_beat] <= i_ram_rd;
          end else begin
            r_rd    <= '0;
            r_rd[0] <= i_ram_rd;
          end
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign core.rd   = r_rd;
  assign core.busy = r_busy;
  assign core.ack  = r_done & ~r_ld;
  assign core.err  = r_err;
  assign o_ram_en   = r_ram_en;
  assign o_ram_we   = r_ram_we;
  assign o_ram_addr = r_ram_addr;
  assign o_ram_wd   = r_ram_wd;

endmodule
